// File: rtl/zdos_trap.sv
// VG93 access trap for floppy-drive emulation: DOS mapping, trap FSM, delayed NMI, cause capture.
// Optional trap watchdog enabled by defining TRAP_TIMEOUT_EN.
module zdos_trap #(
    parameter int NDRV    = 4,
    parameter int NMI_DLY = 3,
    parameter int CW      = 8,
    parameter int TMO     = 4096,
    parameter int DW      = (NDRV > 1) ? $clog2(NDRV) : 1
) (
    input  logic            fclk,
    input  logic            rst_n,
    input  logic            dos_turn_on,
    input  logic            dos_turn_off,
    input  logic            cpm_n,
    output logic            dos,
    input  logic            vg_rdwr_fclk,
    input  logic            vg_wr,
    input  logic [1:0]      vg_a,
    input  logic [DW-1:0]   drv_sel,
    input  logic [NDRV-1:0] fdd_mask,
    input  logic            romnram,
    input  logic            clr_nmi,
    output logic            in_trdemu,
    output logic            nmi_req,
    output logic [DW-1:0]   trap_drv,
    output logic [1:0]      trap_a,
    output logic            trap_wr,
    output logic [CW-1:0]   trap_cnt,
    output logic            tmo_flag
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_TRAP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_dly;
    logic            r_dos;
    logic            r_nmi_req;
    logic [DW-1:0]   r_trap_drv;
    logic [1:0]      r_trap_a;
    logic            r_trap_wr;
    logic [CW-1:0]   r_trap_cnt;
    logic            w_drv_ok;
    logic            w_q;
    logic            w_enter;
    logic            w_fire;
    logic            w_expire;
    logic            w_wdog_hit;

    // Out-of-range drive numbers never trap, even if the mask bit index would alias.
    assign w_drv_ok = (32'(drv_sel) < NDRV) ? fdd_mask[drv_sel] : 1'b0;
    assign w_q      = vg_rdwr_fclk & w_drv_ok & r_dos & romnram;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_fire      = 1'b0;
        w_expire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!clr_nmi && w_q) begin
                    w_state_nxt = S_WAIT;
                    w_enter     = 1'b1;
                end
            end
            S_WAIT: begin
                if (clr_nmi) begin
                    w_state_nxt = S_IDLE;
                end else if (w_wdog_hit) begin
                    w_state_nxt = S_IDLE;
                    w_expire    = 1'b1;
                end else if (r_dly == 4'd1) begin
                    w_state_nxt = S_TRAP;
                    w_fire      = 1'b1;
                end
            end
            S_TRAP: begin
                if (clr_nmi) begin
                    w_state_nxt = S_IDLE;
                end else if (w_wdog_hit) begin
                    w_state_nxt = S_IDLE;
                    w_expire    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_dly      <= '0;
            r_dos      <= 1'b1;
            r_nmi_req  <= 1'b0;
            r_trap_drv <= '0;
            r_trap_a   <= '0;
            r_trap_wr  <= 1'b0;
            r_trap_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_state   <= w_state_nxt;
            r_nmi_req <= w_fire;
            if (w_enter) begin
                r_trap_drv <= drv_sel;
                r_trap_a   <= vg_a;
                r_trap_wr  <= vg_wr;
                r_dly      <= 4'(NMI_DLY);
                if (r_trap_cnt != '1) begin
                    r_trap_cnt <= r_trap_cnt + 1'b1;
                end
            end else if (r_state == S_WAIT) begin
                r_dly <= r_dly - 4'd1;
            end
            if (!cpm_n) begin
                r_dos <= 1'b1;
            end else if (dos_turn_off) begin
                r_dos <= 1'b0;
            end else if (dos_turn_on) begin
                r_dos <= 1'b1;
            end
        end
    end

`ifdef TRAP_TIMEOUT_EN
    localparam int WW = (TMO > 1) ? $clog2(TMO) : 1;

    logic [WW-1:0] r_wdog;
    logic          r_tmo_flag;

    // Counter holds the number of edges already spent in WAIT/TRAP since entry.
    assign w_wdog_hit = (r_wdog == WW'(TMO - 1));

    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog     <= '0;
            r_tmo_flag <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (clr_nmi) begin
                r_tmo_flag <= 1'b0;
            end else if (w_expire) begin
                r_tmo_flag <= 1'b1;
            end
        end
    end

    assign tmo_flag = r_tmo_flag;
`else
    logic w_unused_tmo;

    assign w_wdog_hit   = 1'b0;
    assign w_unused_tmo = TMO[0] ^ w_expire;
    assign tmo_flag     = 1'b0;
`endif

    assign dos       = r_dos;
    assign in_trdemu = (r_state != S_IDLE);
    assign nmi_req   = r_nmi_req;
    assign trap_drv  = r_trap_drv;
    assign trap_a    = r_trap_a;
    assign trap_wr   = r_trap_wr;
    assign trap_cnt  = r_trap_cnt;

endmodule

// File: tb/tb_zdos_trap.sv
// Directed bench for zdos_trap: DOS priority, trap entry/NMI timing, aborts, saturation, watchdog.
module tb_zdos_trap;

    localparam int NDRV = 4;
    localparam int DW   = 2;
    localparam int CW   = 2;

    logic            fclk;
    logic            rst_n;
    logic            dos_turn_on;
    logic            dos_turn_off;
    logic            cpm_n;
    logic            dos;
    logic            vg_rdwr_fclk;
    logic            vg_wr;
    logic [1:0]      vg_a;
    logic [DW-1:0]   drv_sel;
    logic [NDRV-1:0] fdd_mask;
    logic            romnram;
    logic            clr_nmi;
    logic            in_trdemu;
    logic            nmi_req;
    logic [DW-1:0]   trap_drv;
    logic [1:0]      trap_a;
    logic            trap_wr;
    logic [CW-1:0]   trap_cnt;
    logic            tmo_flag;

    int total = 0;
    int bad   = 0;

    zdos_trap #(
        .NDRV    (NDRV),
        .NMI_DLY (3),
        .CW      (CW),
        .TMO     (16)
    ) dut (
        .fclk         (fclk),
        .rst_n        (rst_n),
        .dos_turn_on  (dos_turn_on),
        .dos_turn_off (dos_turn_off),
        .cpm_n        (cpm_n),
        .dos          (dos),
        .vg_rdwr_fclk (vg_rdwr_fclk),
        .vg_wr        (vg_wr),
        .vg_a         (vg_a),
        .drv_sel      (drv_sel),
        .fdd_mask     (fdd_mask),
        .romnram      (romnram),
        .clr_nmi      (clr_nmi),
        .in_trdemu    (in_trdemu),
        .nmi_req      (nmi_req),
        .trap_drv     (trap_drv),
        .trap_a       (trap_a),
        .trap_wr      (trap_wr),
        .trap_cnt     (trap_cnt),
        .tmo_flag     (tmo_flag)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    // Raise the VG93 strobe for exactly one edge (edge N), then drop it.
    task automatic strobe(input logic [DW-1:0] drv, input logic [1:0] a, input logic wr);
        drv_sel      = drv;
        vg_a         = a;
        vg_wr        = wr;
        vg_rdwr_fclk = 1'b1;
        tick();
        vg_rdwr_fclk = 1'b0;
    endtask

    task automatic clear();
        clr_nmi = 1'b1;
        tick();
        clr_nmi = 1'b0;
    endtask

    int pulses;

    initial begin
        rst_n        = 1'b0;
        dos_turn_on  = 1'b0;
        dos_turn_off = 1'b0;
        cpm_n        = 1'b1;
        vg_rdwr_fclk = 1'b0;
        vg_wr        = 1'b0;
        vg_a         = 2'd0;
        drv_sel      = 2'd0;
        fdd_mask     = 4'b0100;
        romnram      = 1'b1;
        clr_nmi      = 1'b0;
        #22;
        check("rst_dos", 32'(dos), 32'd1);
        check("rst_in_trdemu", 32'(in_trdemu), 32'd0);
        check("rst_nmi", 32'(nmi_req), 32'd0);
        check("rst_cause", {27'd0, trap_drv, trap_a, trap_wr}, 32'd0);
        check("rst_cnt", 32'(trap_cnt), 32'd0);
        check("rst_tmo", 32'(tmo_flag), 32'd0);
        rst_n = 1'b1;
        tick();

        // DOS priority: CP/M force beats turn-off, then turn-off beats turn-on.
        cpm_n = 1'b0; dos_turn_off = 1'b1;
        tick();
        check("dos_cpm_force", 32'(dos), 32'd1);
        cpm_n = 1'b1; dos_turn_on = 1'b1;
        tick();
        check("dos_off_wins", 32'(dos), 32'd0);
        dos_turn_off = 1'b0; dos_turn_on = 1'b0;

        // dos=0 disqualifies the trap.
        strobe(2'd2, 2'd3, 1'b1);
        check("no_trap_dos0", 32'(in_trdemu), 32'd0);
        dos_turn_on = 1'b1;
        tick();
        dos_turn_on = 1'b0;
        check("dos_on", 32'(dos), 32'd1);

        // Main trap: in_trdemu from N, NMI pulse at N+3 only.
        strobe(2'd2, 2'd3, 1'b1);
        check("t1_in_trdemu_N", 32'(in_trdemu), 32'd1);
        check("t1_nmi_N", 32'(nmi_req), 32'd0);
        check("t1_cause", {27'd0, trap_drv, trap_a, trap_wr}, {27'd0, 2'd2, 2'd3, 1'b1});
        check("t1_cnt", 32'(trap_cnt), 32'd1);
        tick();
        check("t1_nmi_N1", 32'(nmi_req), 32'd0);
        tick();
        check("t1_nmi_N2", 32'(nmi_req), 32'd0);
        tick();
        check("t1_nmi_N3", 32'(nmi_req), 32'd1);
        tick();
        check("t1_nmi_N4", 32'(nmi_req), 32'd0);
        check("t1_hold", 32'(in_trdemu), 32'd1);
        clear();
        check("t1_exit", 32'(in_trdemu), 32'd0);

        // Unmasked drive and RAM-mapped window do not trap.
        strobe(2'd1, 2'd0, 1'b0);
        check("no_trap_drv1", 32'(in_trdemu), 32'd0);
        romnram = 1'b0;
        strobe(2'd2, 2'd0, 1'b0);
        check("no_trap_ram", 32'(in_trdemu), 32'd0);
        check("no_trap_cnt", 32'(trap_cnt), 32'd1);
        romnram = 1'b1;

        // Re-arm: trap right after an exit, then abort from WAIT.
        strobe(2'd2, 2'd3, 1'b1);
        clear();
        strobe(2'd2, 2'd1, 1'b0);
        check("t2_rearm", 32'(in_trdemu), 32'd1);
        check("t2_cnt", 32'(trap_cnt), 32'd3);
        strobe(2'd2, 2'd0, 1'b1);
        check("t2_no_recapture", {29'd0, trap_a, trap_wr}, {29'd0, 2'd1, 1'b0});
        check("t2_no_count", 32'(trap_cnt), 32'd3);
        clear();
        check("t2_abort", 32'(in_trdemu), 32'd0);
        check("t2_abort_nmi", 32'(nmi_req), 32'd0);
        tick();
        check("t2_no_nmi", 32'(nmi_req), 32'd0);

        // clr_nmi and qualifier in the same IDLE cycle: no entry.
        clr_nmi = 1'b1;
        strobe(2'd2, 2'd2, 1'b1);
        clr_nmi = 1'b0;
        check("clr_wins", 32'(in_trdemu), 32'd0);
        check("clr_wins_cnt", 32'(trap_cnt), 32'd3);

        // Saturation, plus dos falling while trapped leaves the FSM alone.
        strobe(2'd2, 2'd2, 1'b0);
        check("sat_cnt", 32'(trap_cnt), 32'd3);
        dos_turn_off = 1'b1;
        tick();
        dos_turn_off = 1'b0;
        check("dosfall_dos", 32'(dos), 32'd0);
        tick();
        tick();
        check("dosfall_nmi", 32'(nmi_req), 32'd1);
        check("dosfall_hold", 32'(in_trdemu), 32'd1);
        clear();
        dos_turn_on = 1'b1;
        tick();
        dos_turn_on = 1'b0;

        // Long hold: watchdog expiry if built in, otherwise the trap persists.
        strobe(2'd2, 2'd3, 1'b0);
`ifdef TRAP_TIMEOUT_EN
        repeat (15) tick();
        check("wd_before", 32'(in_trdemu), 32'd1);
        tick();
        check("wd_expire", 32'(in_trdemu), 32'd0);
        check("wd_flag", 32'(tmo_flag), 32'd1);
        clear();
        check("wd_flag_clr", 32'(tmo_flag), 32'd0);
`else
        pulses = 0;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if (nmi_req) pulses++;
        end
        check("hold_10k", 32'(in_trdemu), 32'd1);
        check("hold_pulses", 32'(pulses), 32'd1);
        check("hold_tmo", 32'(tmo_flag), 32'd0);
        clear();
        check("hold_exit", 32'(in_trdemu), 32'd0);
`endif

        // Reset mid-trap aborts without a pulse.
        strobe(2'd2, 2'd3, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_mid_in", 32'(in_trdemu), 32'd0);
        check("rst_mid_cnt", 32'(trap_cnt), 32'd0);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (nmi_req) pulses++;
        end
        check("rst_mid_nopulse", 32'(pulses), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zdos_trap.md
ZDOS_TRAP -- requirements
Module: zdos_trap

Interface
Parameters:
REQ-001 NDRV, 4, number of emulated drives (1..16); DW = clog2(NDRV) (min 1), drive-select width.
REQ-002 NMI_DLY, 3, cycles from trap entry to NMI request pulse (1..15).
REQ-003 CW, 8, width of the trap-entry counter.
REQ-004 TMO, 4096, trap watchdog limit in fclk cycles (used only under TRAP_TIMEOUT_EN).

Ports:
REQ-005 fclk  in  1  sole clock, all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 dos_turn_on, dos_turn_off  in  1 each  DOS page enable/disable strobes.
REQ-008 cpm_n  in  1  active-low CP/M force-DOS.
REQ-009 dos  out  1  DOS ROM mapping state.
REQ-010 vg_rdwr_fclk  in  1  one-cycle strobe: CPU access to a VG93 register.
REQ-011 vg_wr  in  1  access direction, 1 = write.
REQ-012 vg_a  in  2  VG93 register index.
REQ-013 drv_sel  in  DW  currently selected drive.
REQ-014 fdd_mask  in  NDRV  per-drive emulation enable.
REQ-015 romnram  in  1  1 = ROM mapped in CPU window.
REQ-016 clr_nmi  in  1  one-cycle strobe: emulator handler exit (out (#BE),a).
REQ-017 in_trdemu  out  1  emulator RAM page #FE mapped.
REQ-018 nmi_req  out  1  one-cycle NMI request pulse.
REQ-019 trap_drv / trap_a / trap_wr  out  DW / 2 / 1  captured cause of last trap.
REQ-020 trap_cnt  out  CW  saturating trap-entry count.
REQ-021 tmo_flag  out  1  sticky watchdog-expiry flag.

Function
REQ-022 dos priority per edge: !cpm_n -> 1; else dos_turn_off -> 0; else dos_turn_on -> 1; else hold.
REQ-023 Trap qualifier q = vg_rdwr_fclk & (drv_sel < NDRV) & fdd_mask[drv_sel] & dos & romnram; drv_sel >= NDRV never qualifies.
REQ-024 FSM states IDLE, WAIT, TRAP; reset to IDLE.
REQ-025 IDLE: q sampled high at edge N -> WAIT, in_trdemu=1 from edge N, trap_drv/trap_a/trap_wr loaded from same-cycle inputs, trap_cnt+1 saturating at all-ones, delay counter loaded.
REQ-026 WAIT: nmi_req high exactly one cycle, asserted at edge N+NMI_DLY, then -> TRAP in same edge.
REQ-027 TRAP: hold in_trdemu=1 until clr_nmi; clr_nmi -> IDLE, in_trdemu=0 next edge.
REQ-028 clr_nmi in WAIT aborts: -> IDLE, in_trdemu=0, no nmi_req pulse.
REQ-029 clr_nmi and q in same IDLE cycle: clr_nmi wins, no trap entry.
REQ-030 q while in WAIT or TRAP ignored: no recapture, no count.
REQ-031 Reaching IDLE re-arms immediately: q in the cycle after exit starts a new trap.
REQ-032 dos falling while in WAIT/TRAP does not affect FSM; only clr_nmi (or watchdog) exits.

Reset
REQ-033 rst_n low: dos=1, in_trdemu=0, nmi_req=0, trap_drv=0, trap_a=0, trap_wr=0, trap_cnt=0, tmo_flag=0, FSM IDLE, counters 0; reset mid-trap aborts without pulse.

Configuration
REQ-034 Macro TRAP_TIMEOUT_EN defined: watchdog counts cycles in WAIT/TRAP; on reaching TMO without clr_nmi, FSM -> IDLE, in_trdemu=0, tmo_flag=1 (sticky, cleared by next clr_nmi or reset); pending nmi_req suppressed if WAIT expires.
REQ-035 Macro TRAP_TIMEOUT_EN undefined: no watchdog logic, tmo_flag tied 0, trap persists until clr_nmi.

Verification
REQ-036 Reset, cpm_n=0 with dos_turn_off=1 -> dos stays 1; cpm_n=1, dos_turn_off=1 -> dos=0 next edge.
REQ-037 NDRV=4, fdd_mask=4'b0100, drv_sel=2, dos=1, romnram=1, vg_a=3, vg_wr=1, strobe at edge N -> in_trdemu=1 at N, nmi_req one cycle at N+3, trap_drv=2, trap_a=3, trap_wr=1, trap_cnt=1.
REQ-038 Same setup, drv_sel=1 or romnram=0 or dos=0 -> no trap, trap_cnt unchanged.
REQ-039 clr_nmi at N+1 (in WAIT) -> in_trdemu=0 at N+2, no nmi_req; clr_nmi with q same cycle in IDLE -> no trap.
REQ-040 CW=2, five trap/clear cycles -> trap_cnt 1,2,3,3,3.
REQ-041 TRAP_TIMEOUT_EN, TMO=16, trap with no clr_nmi -> in_trdemu=0 and tmo_flag=1 after 16 cycles; next clr_nmi clears tmo_flag; without macro in_trdemu stays 1 for 10000 cycles.
